// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Shares the single Common Data Bus between NUM_FUS functional
//            units. Each FU writes into its own small result queue. One
//            queued result per cycle is selected and broadcast as a
//            registered CDB write (value + RS tag + FU id).
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            flush      - synchronous squash of all queued/in-flight results
//            fu_valid   - per-FU result valid
//            fu_result  - per-FU result data (unpacked array)
//            fu_tag     - per-FU destination RS tag (unpacked array)
//            fu_ready   - per-FU queue can accept a result this cycle
//            cdb_valid  - CDB broadcast valid
//            cdb_result - broadcast data
//            cdb_tag    - broadcast RS tag
//            cdb_fu_id  - index of the FU whose result is broadcast
// Config   : CDB_FIXED_PRIO_EN - when defined, the lowest-index non-empty
//            queue always wins and no round-robin pointer exists.
//            Default (undefined) is round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int XLEN         = 32,
  parameter int RS_TAG_WIDTH = 4,
  parameter int NUM_FUS      = 5,
  parameter int BUF_DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_FUS-1:0]           fu_valid,
  input  logic [XLEN-1:0]              fu_result [NUM_FUS],
  input  logic [RS_TAG_WIDTH-1:0]      fu_tag    [NUM_FUS],
  output logic [NUM_FUS-1:0]           fu_ready,
  output logic                         cdb_valid,
  output logic [XLEN-1:0]              cdb_result,
  output logic [RS_TAG_WIDTH-1:0]      cdb_tag,
  output logic [$clog2(NUM_FUS)-1:0]   cdb_fu_id
);

  localparam int c_id_w  = $clog2(NUM_FUS);
  localparam int c_ptr_w = $clog2(BUF_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [NUM_FUS-1:0]      w_req;
  logic [XLEN-1:0]         w_head_result [NUM_FUS];
  logic [RS_TAG_WIDTH-1:0] w_head_tag    [NUM_FUS];
  logic                    w_grant_valid;
  logic [c_id_w-1:0]       w_grant_id;

  // --------------------------------------------------------------------------
  // Per-FU result queues
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FUS; gi++) begin : g_fu
      logic [XLEN-1:0]         r_data [BUF_DEPTH];
      logic [RS_TAG_WIDTH-1:0] r_tagq [BUF_DEPTH];
      logic [c_ptr_w-1:0]      r_wptr;
      logic [c_ptr_w-1:0]      r_rptr;
      logic [c_cnt_w-1:0]      r_count;
      logic                    w_push;
      logic                    w_pop;

      // Ready comes from the registered count only: a full queue stays
      // not-ready during the cycle in which it drains.
      assign fu_ready[gi]      = (r_count != c_cnt_w'(BUF_DEPTH));
      assign w_req[gi]         = (r_count != '0);
      assign w_push            = fu_valid[gi] && fu_ready[gi] && !flush;
      assign w_pop             = w_grant_valid && (w_grant_id == c_id_w'(gi)) && !flush;
      assign w_head_result[gi] = r_data[r_rptr];
      assign w_head_tag[gi]    = r_tagq[r_rptr];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else if (flush) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
          if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
          if (w_push && !w_pop)      r_count <= r_count + c_cnt_w'(1);
          else if (!w_push && w_pop) r_count <= r_count - c_cnt_w'(1);
        end
      end

      // Storage needs no reset: entries are only read when count says valid.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_data[r_wptr] <= fu_result[gi];
          r_tagq[r_wptr] <= fu_tag[gi];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    // Descending scan so the lowest requesting index is assigned last.
    for (int i = NUM_FUS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = c_id_w'(i);
      end
    end
  end
`else
  logic [c_id_w-1:0] r_rr_ptr;
  logic [c_id_w-1:0] w_cand;

  function automatic logic [c_id_w-1:0] rr_index(input logic [c_id_w-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_FUS) sum = sum - NUM_FUS;
    return c_id_w'(sum);
  endfunction

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    // Scan the search order backwards (rr_ptr+NUM_FUS down to rr_ptr+1) so
    // the first requester in search order is the final assignment.
    for (int k = NUM_FUS; k >= 1; k--) begin
      w_cand = rr_index(r_rr_ptr, k);
      if (w_req[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_cand;
      end
    end
  end

  // Reset value NUM_FUS-1 puts FU0 first in the search order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= c_id_w'(NUM_FUS - 1);
    end else if (!flush && w_grant_valid) begin
      r_rr_ptr <= w_grant_id;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Registered CDB broadcast; data fields hold when nothing is granted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid  <= 1'b0;
      cdb_result <= '0;
      cdb_tag    <= '0;
      cdb_fu_id  <= '0;
    end else if (flush) begin
      cdb_valid  <= 1'b0;
    end else if (w_grant_valid) begin
      cdb_valid  <= 1'b1;
      cdb_result <= w_head_result[w_grant_id];
      cdb_tag    <= w_head_tag[w_grant_id];
      cdb_fu_id  <= w_grant_id;
    end else begin
      cdb_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter. A queue-based reference
//            model predicts every broadcast into a scoreboard; an
//            independent monitor pops and compares on each cdb_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int XLEN = 32;
  localparam int TW   = 4;
  localparam int NF   = 5;
  localparam int BD   = 2;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [NF-1:0]   fu_valid = '0;
  logic [XLEN-1:0] fu_result [NF];
  logic [TW-1:0]   fu_tag    [NF];
  logic [NF-1:0]   fu_ready;
  logic            cdb_valid;
  logic [XLEN-1:0] cdb_result;
  logic [TW-1:0]   cdb_tag;
  logic [IDW-1:0]  cdb_fu_id;

  cdb_arbiter #(
    .XLEN(XLEN), .RS_TAG_WIDTH(TW), .NUM_FUS(NF), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fu_valid(fu_valid), .fu_result(fu_result), .fu_tag(fu_tag),
    .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_result(cdb_result),
    .cdb_tag(cdb_tag), .cdb_fu_id(cdb_fu_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [TW-1:0]   tag;
    logic [IDW-1:0]  id;
  } ent_t;

  ent_t mq [NF][$];   // model of each FU queue
  ent_t sb [$];       // expected broadcasts, in order
  int   rr;           // model round-robin pointer
  bit   pend  [NF];   // FU holds a result it has not yet handed over
  ent_t pend_e[NF];
  bit   last_flush;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] got,
                              input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Monitor: one expected entry per observed broadcast.
  always @(negedge clk) begin : mon
    ent_t got;
    ent_t e;
    if (rst_n && cdb_valid) begin
      got = {cdb_result, cdb_tag, cdb_fu_id};
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_bcast: got %h expected none (t=%0t)", got, $time);
      end else begin
        e = sb.pop_front();
        chk("cdb_bcast", got, e);
      end
    end
  end

  // Called at posedge+1: drive inputs for the coming edge, predict its effect,
  // then advance to the next posedge+1.
  task automatic step(input logic [NF-1:0] want, input bit fl);
    logic [NF-1:0] exp_rdy;
    int win;
    for (int i = 0; i < NF; i++) begin
      if (!pend[i] && want[i]) begin
        pend[i]        = 1'b1;
        pend_e[i].res  = $urandom;
        pend_e[i].tag  = TW'($urandom_range(0, 15));
        pend_e[i].id   = IDW'(i);
      end
      fu_valid[i]  = pend[i];
      fu_result[i] = pend_e[i].res;
      fu_tag[i]    = pend_e[i].tag;
    end
    flush = fl;
    if (last_flush) chk("cdb_valid_after_flush", 64'(cdb_valid), 64'(0));
    for (int i = 0; i < NF; i++) exp_rdy[i] = (mq[i].size() != BD);
    chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    if (fl) begin
      for (int i = 0; i < NF; i++) begin
        mq[i].delete();
        pend[i] = 1'b0;
      end
    end else begin
      win = -1;
`ifdef CDB_FIXED_PRIO_EN
      for (int i = 0; i < NF; i++)
        if (win < 0 && mq[i].size() != 0) win = i;
`else
      for (int k = 1; k <= NF; k++) begin
        int c;
        c = (rr + k) % NF;
        if (win < 0 && mq[c].size() != 0) win = c;
      end
`endif
      if (win >= 0) begin
        sb.push_back(mq[win].pop_front());
        rr = win;
      end
      for (int i = 0; i < NF; i++) begin
        if (pend[i] && exp_rdy[i]) begin
          mq[i].push_back(pend_e[i]);
          pend[i] = 1'b0;
        end
      end
    end
    last_flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NF; i++) begin
      mq[i].delete();
      pend[i]     = 1'b0;
      fu_valid[i] = 1'b0;
    end
    sb.delete();
    rr         = NF - 1;
    last_flush = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_cdb_valid"},  64'(cdb_valid),  64'(0));
    chk({tagname, "_cdb_result"}, 64'(cdb_result), 64'(0));
    chk({tagname, "_cdb_tag"},    64'(cdb_tag),    64'(0));
    chk({tagname, "_cdb_fu_id"},  64'(cdb_fu_id),  64'(0));
    chk({tagname, "_fu_ready"},   64'(fu_ready),   64'({NF{1'b1}}));
  endtask

  // Entered at posedge+1; asserts reset between edges.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NF; i++) begin
      fu_result[i] = '0;
      fu_tag[i]    = '0;
      pend_e[i]    = '0;
    end
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single result from FU2: data 0xA5, tag 3.
    pend[2]   = 1'b1;
    pend_e[2] = '{res: 32'hA5, tag: 4'd3, id: 3'd2};
    step('0, 1'b0);
    repeat (4) step('0, 1'b0);

    // All FUs at once, from the post-reset-like pointer (rr=2 after FU2).
    step({NF{1'b1}}, 1'b0);
    repeat (6) step('0, 1'b0);
    // Force rr to 2, then all FUs again -> order 3,4,0,1,2.
    step(5'b00100, 1'b0);
    repeat (3) step('0, 1'b0);
    step({NF{1'b1}}, 1'b0);
    repeat (6) step('0, 1'b0);

    // FU0 and FU1 saturating: backpressure with held results.
    repeat (20) step(5'b00011, 1'b0);
    repeat (6) step('0, 1'b0);

    // Fill FU1, FU3, FU4 then flush.
    step(5'b11010, 1'b0);
    step(5'b11010, 1'b0);
    step(5'b11010, 1'b1);
    repeat (4) step('0, 1'b0);

    // Randomized traffic with occasional flushes.
    repeat (400) step(NF'($urandom), ($urandom_range(0, 40) == 0));

    // Reset in the middle of a burst.
    repeat (4) step({NF{1'b1}}, 1'b0);
    async_reset();
    repeat (3) step(5'b11010, 1'b0);
    repeat (200) step(NF'($urandom), ($urandom_range(0, 40) == 0));

    // Drain.
    repeat (12) step('0, 1'b0);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
